// File: rtl/fft_peak_reader.sv
// Drains one FFT frame (bins 1..N/2-1), tracks the largest |re|+|im| bin and
// presents it over valid/ready. Optional noise floor: define FFT_READER_THRESH_EN.
module fft_peak_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 32,
  parameter int M         = $clog2(N),
  parameter int MIN_MAG   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic [2*BIT_WIDTH-1:0] rd_data,
  output logic [M-1:0]           rd_adr,
  output logic                   busy,
  output logic [M-1:0]           peak_bin,
  output logic [BIT_WIDTH:0]     peak_mag,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   dropped_frame
);

  if (N < 8 || (N & (N - 1)) != 0 || MIN_MAG < 0) begin : g_bad_param
    $error("fft_peak_reader: N must be a power of two >= 8 and MIN_MAG >= 0");
  end

  localparam logic [M-1:0] LAST_BIN = M'(N / 2 - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, HOLD} state_t;

  state_t               state;
  logic                 done_q;
  logic                 trigger;
  logic [M-1:0]         adr_q;
  logic                 data_valid;
  logic [M-1:0]         max_bin;
  logic [BIT_WIDTH:0]   max_mag;
  logic [BIT_WIDTH:0]   cur_mag;
  logic [M-1:0]         next_bin;
  logic [BIT_WIDTH:0]   next_mag;
  logic [M-1:0]         report_bin;

  // |x| of the most negative value wraps to 2^(BIT_WIDTH-1), which is the
  // correct unsigned magnitude in BIT_WIDTH bits.
  function automatic logic [BIT_WIDTH-1:0] abs_val(input logic [BIT_WIDTH-1:0] x);
    return x[BIT_WIDTH-1] ? (~x + BIT_WIDTH'(1)) : x;
  endfunction

  assign trigger = fft_done & ~done_q;
  assign cur_mag = {1'b0, abs_val(rd_data[2*BIT_WIDTH-1:BIT_WIDTH])}
                 + {1'b0, abs_val(rd_data[BIT_WIDTH-1:0])};

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    next_bin = max_bin;
    next_mag = max_mag;
    if (data_valid && cur_mag > max_mag) begin
      next_bin = adr_q;
      next_mag = cur_mag;
    end
  end

`ifdef FFT_READER_THRESH_EN
  assign report_bin = (next_mag < (BIT_WIDTH+1)'(MIN_MAG)) ? '0 : next_bin;
`else
  assign report_bin = next_bin;
`endif

  // NOTE: state uses non-blocking assignments only; done_q resets to 1 so an
  // fft_done level held through reset is not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      done_q        <= 1'b1;
      rd_adr        <= '0;
      busy          <= 1'b0;
      adr_q         <= '0;
      data_valid    <= 1'b0;
      max_bin       <= '0;
      max_mag       <= '0;
      peak_bin      <= '0;
      peak_mag      <= '0;
      result_valid  <= 1'b0;
      dropped_frame <= 1'b0;
    end else begin
      done_q     <= fft_done;
      adr_q      <= rd_adr;
      data_valid <= (state == READ);
      max_bin    <= next_bin;
      max_mag    <= next_mag;

      if (trigger && state != IDLE) dropped_frame <= 1'b1;

      case (state)
        IDLE: begin
          rd_adr <= '0;
          if (trigger) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_adr  <= M'(1);
            max_bin <= '0;
            max_mag <= '0;
          end
        end
        READ: begin
          if (rd_adr == LAST_BIN) begin
            state  <= FLUSH;
            rd_adr <= '0;
          end else begin
            rd_adr <= rd_adr + M'(1);
          end
        end
        FLUSH: begin
          // Last sample arrives this cycle, so the report takes the merged max.
          state        <= HOLD;
          result_valid <= 1'b1;
          peak_bin     <= report_bin;
          peak_mag     <= next_mag;
        end
        HOLD: begin
          if (result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_reader.sv
// Directed bench for fft_peak_reader: RAM model with 1-cycle read latency,
// expected results queued at trigger and checked by a handshake monitor.
module tb_fft_peak_reader;

  localparam int BW = 16;
  localparam int N  = 32;
  localparam int M  = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            fft_done;
  logic [2*BW-1:0] rd_data;
  logic [M-1:0]    rd_adr;
  logic            busy;
  logic [M-1:0]    peak_bin;
  logic [BW:0]     peak_mag;
  logic            result_valid;
  logic            result_ready;
  logic            dropped_frame;

  logic [2*BW-1:0] mem [0:N-1];
  logic [M+BW:0]   sb [$];
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  fft_peak_reader #(.BIT_WIDTH(BW), .N(N), .MIN_MAG(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .fft_done     (fft_done),
    .rd_data      (rd_data),
    .rd_adr       (rd_adr),
    .busy         (busy),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .dropped_frame(dropped_frame)
  );

  always @(posedge clk) rd_data <= mem[rd_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected result per completed handshake.
  always @(negedge clk) begin
    if (!reset && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(peak_bin), 32'hffff_ffff);
      end else begin
        logic [M+BW:0] e;
        e = sb.pop_front();
        check("peak_bin", 32'(peak_bin), 32'(e[M+BW:BW+1]));
        check("peak_mag", 32'(peak_mag), 32'(e[BW:0]));
      end
    end
  end

  function automatic logic [2*BW-1:0] pk(input int re, input int im);
    return {BW'(re), BW'(im)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // mode 0: normal, 1: backpressure with overrun pulse, 2: ready raised early.
  task automatic run_frame(input logic [M-1:0] eb, input logic [BW:0] em, input int mode);
    @(posedge clk); #1;
    fft_done = 1'b1;
    sb.push_back({eb, em});
    for (int k = 1; k <= N/2-1; k++) begin
      @(posedge clk); #1;
      if (k == 1) fft_done = 1'b0;
      if (mode == 2 && k == 3) result_ready = 1'b1;
      check($sformatf("rd_adr_T+%0d", k), 32'(rd_adr), 32'(k));
    end
    @(posedge clk); #1;
    check("flush_rd_adr", 32'(rd_adr), 0);
    check("flush_valid", 32'(result_valid), 0);
    check("flush_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("valid_T+17", 32'(result_valid), 1);
    if (mode == 1) begin
      for (int c = 0; c < 5; c++) begin
        check("bp_valid", 32'(result_valid), 1);
        check("bp_peak_bin", 32'(peak_bin), 32'(eb));
        check("bp_peak_mag", 32'(peak_mag), 32'(em));
        if (c == 1) fft_done = 1'b1;
        if (c == 2) fft_done = 1'b0;
        @(posedge clk); #1;
      end
      check("dropped_frame_set", 32'(dropped_frame), 1);
      check("bp_still_busy", 32'(busy), 1);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("valid_drop", 32'(result_valid), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    fft_done = 1'b1;
    result_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_adr", 32'(rd_adr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_peak_bin", 32'(peak_bin), 0);
    check("rst_peak_mag", 32'(peak_mag), 0);
    check("rst_dropped", 32'(dropped_frame), 0);
    reset = 1'b0;
    // fft_done held high through reset must not start a frame.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_start_after_rst", 32'(busy), 0);
    end
    fft_done = 1'b0;
    @(posedge clk); #1;

    clear_mem();
    mem[5] = pk(1000, -200);
    run_frame(5'd5, 17'd1200, 0);
    check("no_drop_yet", 32'(dropped_frame), 0);

    clear_mem();
    mem[3]  = pk(500, 0);
    mem[7]  = pk(-300, 200);
    mem[0]  = pk(30000, 0);
    mem[20] = pk(32000, 0);
    run_frame(5'd3, 17'd500, 0);

    clear_mem();
    mem[9] = pk(-32768, -32768);
    run_frame(5'd9, 17'd65536, 0);

    clear_mem();
    mem[1]  = pk(50, 0);
    mem[15] = pk(-100, -100);
    mem[16] = pk(20000, 0);
    run_frame(5'd15, 17'd200, 2);

    clear_mem();
    run_frame(5'd0, 17'd0, 0);

    clear_mem();
    mem[5] = pk(1000, -200);
    run_frame(5'd5, 17'd1200, 1);

    clear_mem();
    mem[4] = pk(30, 20);
`ifdef FFT_READER_THRESH_EN
    run_frame(5'd0, 17'd50, 0);
`else
    run_frame(5'd4, 17'd50, 0);
`endif

    // Reset mid-READ with fft_done held high.
    clear_mem();
    mem[2] = pk(700, 0);
    @(posedge clk); #1;
    fft_done = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_rd_adr", 32'(rd_adr), 6);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_rd_adr", 32'(rd_adr), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_dropped", 32'(dropped_frame), 0);
    check("midrst_peak_mag", 32'(peak_mag), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_restart", 32'(busy), 0);
    end
    fft_done = 1'b0;
    @(posedge clk); #1;
    run_frame(5'd2, 17'd700, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
